// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable patterns and access decode helpers.
package lsu_pkg;

   localparam int unsigned DefaultTimeoutCycles = 255;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   // Byte-enable patterns before lane shifting
   localparam logic [3:0] BeByte = 4'b0001;
   localparam logic [3:0] BeHalf = 4'b0011;
   localparam logic [3:0] BeWord = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp
   } lsu_state_e;

   // High when the access is misaligned or its funct3 is not a legal encoding
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
      logic err;
      case (f3)
         F3Byte:  err = 1'b0;
         F3Half:  err = lo[0];
         F3Word:  err = (lo != 2'b00);
         F3ByteU: err = we;
         F3HalfU: err = we | lo[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

   // Loads always fetch the full word; stores enable only the addressed lanes
   function automatic logic [3:0] byte_enable(input logic       we,
                                              input logic [2:0] f3,
                                              input logic [1:0] lo);
      logic [3:0] be;
      if (!we) begin
         be = BeWord;
      end else begin
         case (f3)
            F3Byte:  be = BeByte << lo;
            F3Half:  be = BeHalf << {lo[1], 1'b0};
            default: be = BeWord;
         endcase
      end
      return be;
   endfunction

   // Replicate store data across lanes so the byte enables pick the right one
   function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                              input logic [31:0] wdata);
      logic [31:0] data;
      case (f3)
         F3Byte:  data = {4{wdata[7:0]}};
         F3Half:  data = {2{wdata[15:0]}};
         default: data = wdata;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a memory word and sign/zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  f3,
   output logic [31:0] rsp_rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension according to the load type
   always_comb begin
      byte_sel  = 8'h00;
      half_sel  = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      rsp_rdata = mem_rdata;
      case (addr_lo)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      case (f3)
         F3Byte:  rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
         F3ByteU: rsp_rdata = {24'h000000, byte_sel};
         F3Half:  rsp_rdata = {{16{half_sel[15]}}, half_sel};
         F3HalfU: rsp_rdata = {16'h0000, half_sel};
         default: rsp_rdata = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, issues a single memory
// bus request, and returns a one-cycle response with formatted load data.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_f3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_e      state;
   logic [CntW-1:0] tmo_cnt;
   logic [2:0]      acc_f3;
   logic [1:0]      acc_lo;
   logic [31:0]     load_data;

   lsu_load_align u_load_align (
      .mem_rdata (mem_rdata),
      .addr_lo   (acc_lo),
      .f3        (acc_f3),
      .rsp_rdata (load_data)
   );

   // Access FSM with all bus and response outputs registered
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= StIdle;
         tmo_cnt   <= '0;
         acc_f3    <= 3'b000;
         acc_lo    <= 2'b00;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'h0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  acc_f3    <= req_f3;
                  acc_lo    <= req_addr[1:0];
                  if (access_err(req_we, req_f3, req_addr[1:0])) begin
                     // Bad access never reaches the bus
                     state     <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end else begin
                     state     <= StReq;
                     tmo_cnt   <= '0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= byte_enable(req_we, req_f3, req_addr[1:0]);
                     mem_wdata <= store_data(req_f3, req_wdata);
                  end
               end
            end
            StReq: begin
               // An ack in the final allowed cycle still wins over the timeout
               if (mem_ack) begin
                  state     <= StResp;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= mem_we ? 32'h0 : load_data;
               end else if (tmo_cnt == TmoLast) begin
                  state     <= StResp;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 32'h0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            StResp: begin
               state     <= StIdle;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= StIdle;
               rsp_valid <= 1'b0;
               mem_req   <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed accesses and
// plays the memory; a monitor checks every response against queued expectations.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_f3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_f3    (req_f3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding expectation
   always @(negedge CLK) begin
      if (RESET !== 1'b1 && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check32({e.name, "_rdata"}, rsp_rdata, e.rdata);
            check32({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
            check32({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Issue one access and act as the memory; ack_at < 0 means never acknowledge
   task automatic access(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memword, input int ack_at,
                         input logic early_err, input logic [31:0] exp_maddr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int   w;
      int   acc;
      int   delta;
      exp_t e;
      @(negedge CLK);
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      check32({name, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_f3    = f3;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      req_wdata = 32'h5A5A_5A5A;
      acc = cyc;
      if (early_err) delta = 0;
      else if (ack_at >= 0) delta = 1 + ack_at;
      else delta = TMO;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = acc + delta;
      e.name  = name;
      exp_q.push_back(e);
      if (early_err) begin
         @(negedge CLK);
         check32({name, "_no_mem_req"}, 32'(mem_req), 32'd0);
      end else begin
         for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            check32({name, "_mem_req"}, 32'(mem_req), 32'd1);
            if (k == 0) begin
               check32({name, "_mem_addr"}, mem_addr, exp_maddr);
               check32({name, "_mem_be"}, 32'(mem_be), 32'(exp_be));
               check32({name, "_mem_we"}, 32'(mem_we), 32'(we));
               check32({name, "_mem_wdata"}, mem_wdata, exp_wdata);
            end
            if (k == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = memword;
               @(posedge CLK);
               #1;
               mem_ack   = 1'b0;
               mem_rdata = $urandom;
               break;
            end
            if (ack_at < 0 && k == TMO - 1) begin
               @(posedge CLK);
               #1;
               @(negedge CLK);
               check32({name, "_mem_req_dropped"}, 32'(mem_req), 32'd0);
               // Late ack during the response and following idle cycles
               mem_ack   = 1'b1;
               mem_rdata = 32'hFFFF_FFFF;
               for (int j = 0; j < 2; j++) begin
                  @(negedge CLK);
                  check32({name, "_late_ack_no_rsp"}, 32'(rsp_valid), 32'd0);
                  check32({name, "_late_ack_no_req"}, 32'(mem_req), 32'd0);
               end
               mem_ack = 1'b0;
               break;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_f3    = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check32("rst_req_ready", 32'(req_ready), 32'd1);
      check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check32("rst_rsp_err", 32'(rsp_err), 32'd0);
      check32("rst_rsp_rdata", rsp_rdata, 32'h0);
      check32("rst_mem_req", 32'(mem_req), 32'd0);
      check32("rst_mem_we", 32'(mem_we), 32'd0);
      check32("rst_mem_be", 32'(mem_be), 32'd0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      check32("rst_mem_wdata", mem_wdata, 32'h0);
      RESET = 1'b0;

      //     name        we    f3      addr          wdata         memword      ack err
      //     maddr         be       mem_wdata     rdata         err
      access("lb_103",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0,
             32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0);
      access("sh_22",    1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 32'hDEAD_BEEF, 0, 1'b0,
             32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
      access("lw_6_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1,
             32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
      access("lhu_tmo",  1'b0, 3'b101, 32'h0000_0010, 32'h0,        32'h0,       -1, 1'b0,
             32'h0000_0010, 4'b1111, 32'h0,        32'h0,        1'b1);
      access("sb_7",     1'b1, 3'b000, 32'h0000_0007, 32'h1234_56A5, 32'h0,        2, 1'b0,
             32'h0000_0004, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0);
      access("lh_12",    1'b0, 3'b001, 32'h0000_0012, 32'h0,        32'h8001_7FFF, 1, 1'b0,
             32'h0000_0010, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b0);
      access("lw_8",     1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 0, 1'b0,
             32'h0000_0008, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
      access("sw_ack_last", 1'b1, 3'b010, 32'h0000_000C, 32'h1122_3344, 32'h0,     3, 1'b0,
             32'h0000_000C, 4'b1111, 32'h1122_3344, 32'h0,        1'b0);
      access("ld_f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0,       32'h0,        0, 1'b1,
             32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
      access("st_f3_100", 1'b1, 3'b100, 32'h0000_0000, 32'h0,       32'h0,        0, 1'b1,
             32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
      access("sh_1_mis", 1'b1, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 1'b1,
             32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
      access("lb_0_pos", 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1'b0,
             32'h0000_0000, 4'b1111, 32'h0,        32'h0000_007F, 1'b0);

      // Reset while a load is pending, with ack and a new request at the same edge
      @(negedge CLK);
      while (req_ready !== 1'b1) @(negedge CLK);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_f3    = 3'b010;
      req_addr  = 32'h0000_0040;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      @(negedge CLK);
      check32("rstmid_in_req", 32'(mem_req), 32'd1);
      RESET     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      req_valid = 1'b1;
      @(negedge CLK);
      check32("rstmid_mem_req", 32'(mem_req), 32'd0);
      check32("rstmid_ready", 32'(req_ready), 32'd1);
      check32("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      RESET     = 1'b0;
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      @(negedge CLK);
      check32("rstmid_rsp_after", 32'(rsp_valid), 32'd0);

      access("lbu_1",    1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_9A00, 0, 1'b0,
             32'h0000_0000, 4'b1111, 32'h0,        32'h0000_009A, 1'b0);

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge CLK);
      repeat (2) @(negedge CLK);
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL %s_missing: got no response expected one by cycle %0d", e.name, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles in REQ awaiting mem_ack before an error response.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset RESET, synchronous, active-high; clock CLK.
REQ-004 req_valid  input  1  core access request.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_f3  input  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-008 req_addr  input  32  byte address, ALU sum rs1+imm.
REQ-009 req_wdata  input  32  store data, rs2.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  misaligned, illegal funct3 or timeout; valid with rsp_valid.
REQ-013 mem_req  output  1  memory bus request.
REQ-014 mem_we  output  1  memory write.
REQ-015 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  memory completion.
REQ-019 mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-020 FSM states IDLE, REQ, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE & req_valid: capture we, f3, addr, wdata; legal -> REQ, illegal/misaligned -> RESP with err=1 and no mem_req.
REQ-022 Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
REQ-023 Illegal funct3: loads 011/110/111; stores 011..111.
REQ-024 REQ: mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack sampled high; mem_ack in the first REQ cycle counts.
REQ-025 mem_ack in REQ: register formatted data, -> RESP; mem_ack outside REQ ignored.
REQ-026 Timeout counter clears on REQ entry; at TIMEOUT_CYCLES cycles without ack -> RESP with err=1, mem_req deasserts.
REQ-027 RESP: rsp_valid=1 for exactly one cycle, then IDLE; next request acceptable the following cycle.
REQ-028 Latency: accept at edge N; with ack in first REQ cycle, rsp_valid high in cycle N+2; error response in cycle N+1.
REQ-029 mem_be: sb 0001<<addr[1:0]; sh 0011<<{addr[1],0}; sw 1111; loads 1111.
REQ-030 mem_wdata: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-031 Load lane: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-032 rsp_rdata, rsp_err hold last values between pulses; qualify only with rsp_valid.

Reset
REQ-033 RESET: state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-034 RESET mid-REQ: mem_req low next cycle, transaction dropped, no rsp_valid; RESET dominates simultaneous mem_ack or req_valid.

Structure
REQ-035 Shared package lsu_pkg: funct3 encodings, FSM state enum, byte-enable constants, default TIMEOUT_CYCLES.
REQ-036 One combinational sub-module lsu_load_align (mem_rdata, addr[1:0], f3 -> rsp_rdata); FSM, counter and store formatting in load_store_unit.

Verification
REQ-037 lb addr 0x103, mem_rdata 0x80FF_1234, ack in first REQ cycle -> mem_addr 0x100, mem_be 1111, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid 2 cycles after accept.
REQ-038 sh addr 0x22, wdata 0x0000_ABCD -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we 1, rsp_rdata 0, err 0.
REQ-039 lw addr 0x6 -> rsp_valid next cycle, err 1, mem_req never asserted.
REQ-040 TIMEOUT_CYCLES=4, lhu addr 0x10, no ack -> mem_req high 4 cycles, then rsp err 1; late mem_ack ignored.
REQ-041 RESET during REQ (ack pending) -> mem_req 0 next cycle, no rsp_valid, req_ready 1; subsequent lbu 0x1 of 0x0000_9A00 returns 0x0000_009A.
